// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic operand feeder slice.
package systolic_pkg;

    localparam int unsigned DEF_M    = 8;
    localparam int unsigned DEF_N    = 8;
    localparam int unsigned DEF_KMAX = 16;
    localparam int unsigned DEF_DW   = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } feeder_state_e;

    typedef enum logic {
        SEL_A = 1'b0,
        SEL_B = 1'b1
    } load_sel_e;

    // Index width that never collapses to zero bits.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 32'd1) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/systolic_k_feeder_if.sv
// Load port, control and step handshake between host/array and the K feeder.
interface systolic_k_feeder_if #(
    parameter int unsigned M    = systolic_pkg::DEF_M,
    parameter int unsigned N    = systolic_pkg::DEF_N,
    parameter int unsigned KMAX = systolic_pkg::DEF_KMAX,
    parameter int unsigned DW   = systolic_pkg::DEF_DW
);
    import systolic_pkg::*;

    localparam int unsigned KW = clog2_min1(KMAX);
    localparam int unsigned IW = clog2_min1((M > N) ? M : N);

    logic                 load_en;
    load_sel_e            load_sel;
    logic [KW-1:0]        load_k;
    logic [IW-1:0]        load_idx;
    logic [DW-1:0]        load_data;
    logic                 start;
    logic [15:0]          K;
    logic                 done_clear;
    logic                 step_valid;
    logic                 step_ready;
    logic [M-1:0][DW-1:0] a_row_out;
    logic [N-1:0][DW-1:0] b_col_out;
    logic                 k_first;
    logic                 k_last;
    logic [KW-1:0]        k_idx;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic                 load_drop;

    modport slave (
        input  load_en, load_sel, load_k, load_idx, load_data,
        input  start, K, done_clear, step_ready,
        output step_valid, a_row_out, b_col_out, k_first, k_last, k_idx,
        output busy, done, err, load_drop
    );

    modport master (
        output load_en, load_sel, load_k, load_idx, load_data,
        output start, K, done_clear, step_ready,
        input  step_valid, a_row_out, b_col_out, k_first, k_last, k_idx,
        input  busy, done, err, load_drop
    );

endinterface

// File: rtl/systolic_operand_buf.sv
// A (M x KMAX) and B (KMAX x N) element stores with a registered k-slice read port.
module systolic_operand_buf
    import systolic_pkg::*;
#(
    parameter int unsigned M    = DEF_M,
    parameter int unsigned N    = DEF_N,
    parameter int unsigned KMAX = DEF_KMAX,
    parameter int unsigned DW   = DEF_DW,
    parameter int unsigned KW   = clog2_min1(KMAX),
    parameter int unsigned IW   = clog2_min1((M > N) ? M : N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  load_sel_e            wr_sel,
    input  logic [KW-1:0]        wr_k,
    input  logic [IW-1:0]        wr_idx,
    input  logic [DW-1:0]        wr_data,
    input  logic                 rd_en,
    input  logic [KW-1:0]        rd_k,
    output logic [M-1:0][DW-1:0] a_col,
    output logic [N-1:0][DW-1:0] b_row
);

    logic [DW-1:0] a_mem [M][KMAX];
    logic [DW-1:0] b_mem [KMAX][N];

    // Element storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (wr_sel == SEL_A) a_mem[wr_idx][wr_k] <= wr_data;
            else                 b_mem[wr_k][wr_idx] <= wr_data;
        end
    end

    for (genvar i = 0; i < M; i++) begin : g_a_rd
        always_ff @(posedge clk) begin
            if (!rst)       a_col[i] <= '0;
            else if (rd_en) a_col[i] <= a_mem[i][rd_k];
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_b_rd
        always_ff @(posedge clk) begin
            if (!rst)       b_row[j] <= '0;
            else if (rd_en) b_row[j] <= b_mem[rd_k][j];
        end
    end

endmodule

// File: rtl/systolic_k_feeder.sv
// Issues K operand slices (A column k, B row k) to the systolic array over a valid/ready step port.
module systolic_k_feeder
    import systolic_pkg::*;
#(
    parameter int unsigned M    = DEF_M,
    parameter int unsigned N    = DEF_N,
    parameter int unsigned KMAX = DEF_KMAX,
    parameter int unsigned DW   = DEF_DW
) (
    input logic                 clk,
    input logic                 rst,
    systolic_k_feeder_if.slave  bus
);

    localparam int unsigned KW  = clog2_min1(KMAX);
    localparam int unsigned IW  = clog2_min1((M > N) ? M : N);
    localparam int unsigned KLW = clog2_min1(KMAX + 1);

    feeder_state_e  state_q, state_d;
    logic [KLW-1:0] klat_q, klat_d;
    logic [KW-1:0]  k_q, k_d, rd_k;
    logic           valid_q, valid_d, first_q, first_d, last_q, last_d;
    logic           err_q, err_d, drop_q, drop_d, busy_q, done_q;
    logic           start_ok, k_zero, k_over, in_range, wr_ok, rd_en, hs, hs_last;

    assign start_ok = bus.start && (state_q != ISSUE);
    assign k_zero   = (bus.K == 16'd0);
    assign k_over   = (bus.K > 16'(KMAX));
    assign in_range = (32'(bus.load_k) < KMAX) &&
                      ((bus.load_sel == SEL_A) ? (32'(bus.load_idx) < M) : (32'(bus.load_idx) < N));
    assign wr_ok    = bus.load_en && (state_q != ISSUE) && in_range;
    assign hs       = valid_q && bus.step_ready;
    assign hs_last  = hs && (KLW'(k_q) == klat_q - KLW'(1));

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            klat_q  <= '0;
            k_q     <= '0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            drop_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            klat_q  <= klat_d;
            k_q     <= k_d;
            valid_q <= valid_d;
            first_q <= first_d;
            last_q  <= last_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
            busy_q  <= (state_d == ISSUE);
            done_q  <= (state_d == DONE);
        end
    end

    // Next state; start beats done_clear when both arrive in DONE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start_ok) state_d = (k_zero || k_over) ? DONE : ISSUE;
            DONE: begin
                if (start_ok)            state_d = (k_zero || k_over) ? DONE : ISSUE;
                else if (bus.done_clear) state_d = IDLE;
            end
            ISSUE: if (hs_last) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Slice sequencing, flags and buffer read requests.
    always_comb begin
        klat_d  = klat_q;
        k_d     = k_q;
        valid_d = valid_q;
        first_d = first_q;
        last_d  = last_q;
        err_d   = err_q;
        rd_en   = 1'b0;
        rd_k    = k_q;
        drop_d  = bus.load_en && !wr_ok;
        unique case (state_q)
            IDLE, DONE: begin
                if (start_ok) begin
                    err_d   = k_over;
                    valid_d = 1'b0;
                    if (!k_zero && !k_over) begin
                        klat_d  = KLW'(bus.K);
                        k_d     = '0;
                        valid_d = 1'b1;
                        first_d = 1'b1;
                        last_d  = (bus.K == 16'd1);
                        rd_en   = 1'b1;
                        rd_k    = '0;
                    end
                end else if ((state_q == DONE) && bus.done_clear) begin
                    err_d = 1'b0;
                end
            end
            ISSUE: begin
                if (hs_last) begin
                    valid_d = 1'b0;
                    first_d = 1'b0;
                    last_d  = 1'b0;
                end else if (hs) begin
                    k_d     = k_q + KW'(1);
                    rd_en   = 1'b1;
                    rd_k    = k_q + KW'(1);
                    first_d = 1'b0;
                    last_d  = (KLW'(k_q) + KLW'(2) == klat_q);
                end
            end
            default: ;
        endcase
    end

    systolic_operand_buf #(
        .M(M), .N(N), .KMAX(KMAX), .DW(DW), .KW(KW), .IW(IW)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_ok),
        .wr_sel  (bus.load_sel),
        .wr_k    (bus.load_k),
        .wr_idx  (bus.load_idx),
        .wr_data (bus.load_data),
        .rd_en   (rd_en),
        .rd_k    (rd_k),
        .a_col   (bus.a_row_out),
        .b_row   (bus.b_col_out)
    );

    assign bus.step_valid = valid_q;
    assign bus.k_first    = first_q;
    assign bus.k_last     = last_q;
    assign bus.k_idx      = k_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.load_drop  = drop_q;

endmodule
